// File: rtl/shift_in_pkg.sv
// Shared types and constants for the 74HC165-style shift register reader.
package shift_in_pkg;

  localparam int PHASES = 8;
  localparam int BITS   = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'b00,
    CMD_SHIFT = 2'b01,
    CMD_CE    = 2'b10,
    CMD_LDSH  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REC,
    S_SHIFT,
    S_FIN
  } state_e;

  // Q7 is taken mid CP-low window so it has settled since the previous rising edge.
  function automatic logic sample_phase(input logic [CNT_W-1:0] cnt);
    return cnt[2:0] == 3'd3;
  endfunction

endpackage

// File: rtl/shift_in_if.sv
// Command/response bus between a controller and the shift_in reader.
interface shift_in_if;
  logic       vld;
  logic [1:0] cmd;
  logic       cmd_arg;
  logic       busy;
  logic       done;
  logic [7:0] dout;

  modport master (output vld, cmd, cmd_arg, input busy, done, dout);
  modport slave  (input vld, cmd, cmd_arg, output busy, done, dout);
endinterface

// File: rtl/shift_in_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; clears to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 2'b00;
    else        ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];
endmodule

// File: rtl/shift_in.sv
// Reader FSM for a 74HC165 chain: drives PL_n/CP/CE_n, samples Q7, returns one byte per shift.
module shift_in
  import shift_in_pkg::*;
#(
  parameter int PL_W   = 4,
  parameter int PL_REC = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  shift_in_if.slave bus,
  output logic     sft_pl_n,
  output logic     sft_cp,
  output logic     sft_ce_n,
  input  logic     sft_q7
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ldsh_q, ldsh_d;
  logic [BITS-1:0]    sh_q, sh_d;
  logic [BITS-1:0]    dout_q, dout_d;
  logic               pl_n_q, pl_n_d;
  logic               cp_q, cp_d;
  logic               ce_n_q, ce_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               q7_s;
  logic               accept;

  sync2 u_q7_sync (.clk(clk), .rst_n(rst_n), .d_i(sft_q7), .q_o(q7_s));

  assign accept = bus.vld && !busy_q && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ldsh_q  <= 1'b0;
      sh_q    <= '0;
      dout_q  <= '0;
      pl_n_q  <= 1'b1;
      cp_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ldsh_q  <= ldsh_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      pl_n_q  <= pl_n_d;
      cp_q    <= cp_d;
      ce_n_q  <= ce_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // One counter is reused for LOAD width, REC width and the {bit,phase} shift sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ldsh_d  = ldsh_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          case (cmd_e'(bus.cmd))
            CMD_LOAD:  begin state_d = S_LOAD;  ldsh_d = 1'b0; end
            CMD_SHIFT: begin state_d = S_SHIFT; ldsh_d = 1'b0; end
            CMD_LDSH:  begin state_d = S_LOAD;  ldsh_d = 1'b1; end
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_W'(PL_W - 1)) begin
          state_d = S_REC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REC: begin
        if (cnt_q == CNT_W'(PL_REC - 1)) begin
          state_d = ldsh_q ? S_SHIFT : S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(PHASES * BITS - 1)) begin
          state_d = S_FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are registered from next-state so they line up with the state they belong to.
  always_comb begin
    sh_d   = sh_q;
    dout_d = dout_q;
    ce_n_d = ce_n_q;
    if (state_q == S_SHIFT && sample_phase(cnt_q))
      sh_d = {sh_q[BITS-2:0], q7_s};
    if (state_q == S_SHIFT && state_d == S_FIN)
      dout_d = sh_q;
    if (accept && cmd_e'(bus.cmd) == CMD_CE)
      ce_n_d = bus.cmd_arg;
    pl_n_d = (state_d != S_LOAD);
    cp_d   = (state_d == S_SHIFT) && cnt_d[2];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN) || (accept && cmd_e'(bus.cmd) == CMD_CE);
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign sft_pl_n  = pl_n_q;
  assign sft_cp    = cp_q;
  assign sft_ce_n  = ce_n_q;

endmodule

// File: doc/shift_in.md
# shift_in

Parallel-in/serial-out reader for a 74HC165-style input shift register chain, the read-direction counterpart of the 74HC595 output driver on the TWI peripheral bus. Accepts single-cycle commands (parallel load, shift one byte, load-and-shift, clock-enable control). Drives the chip's PL_n, CP and CE_n pins and samples Q7 through a synchronizer. Returns one byte per shift command with a done pulse.

## Interface
- PL_W, 4: parallel-load low-pulse width, clk cycles (>=2)
- PL_REC, 2: PL_n high recovery before shifting or done, clk cycles (>=1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- vld  in  1  command strobe; accepted only when busy=0
- cmd  in  2  00 load, 01 shift byte, 10 set CE_n, 11 load then shift byte
- cmd_arg  in  1  CE_n value for cmd 10; ignored otherwise
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- dout  out  8  last byte shifted in, MSB = first bit read
- sft_pl_n  out  1  parallel load, active low
- sft_cp  out  1  shift clock; chip shifts on rising edge
- sft_ce_n  out  1  clock enable, active low
- sft_q7  in  1  serial data from chip (asynchronous)

## Operation
- Reset values: busy=0, done=0, dout=8'h00, sft_pl_n=1, sft_cp=0, sft_ce_n=1. All state registers and the synchronizer flops clear.
- States: IDLE, LOAD, REC, SHIFT, FIN.
- IDLE: vld&&!busy latches cmd.
  - 00 -> LOAD.
  - 01 -> SHIFT.
  - 11 -> LOAD, with a flag to enter SHIFT after REC.
  - 10: sft_ce_n<=cmd_arg at the acceptance edge; done pulses the next cycle; busy never asserts.
- LOAD: sft_pl_n=0 for PL_W cycles, then REC.
- REC: sft_pl_n=1 for PL_REC cycles. Cmd 00 -> FIN; cmd 11 -> SHIFT.
- SHIFT: 6-bit counter {bit[2:0],phase[2:0]} runs from 0 to 63.
  - sft_cp=phase[2]: low on phases 0-3, high on phases 4-7.
  - At phase 3 the synchronized Q7 shifts in: sh<={sh[6:0],q7_s}.
  - After bit 7 phase 7 -> FIN.
- FIN: one cycle, done=1, and dout<=sh is loaded on the edge entering FIN. Then IDLE.
- sft_q7 passes through a 2-flop synchronizer before use. q7_s at phase 3 reflects the pin about 2 cycles earlier, inside the CP-low window.
- First bit captured is D7 of the nearest chip, present after load before any CP edge. 8 CP rising edges occur per byte; the 8th advances the chain for the next byte command.
- CE_n is not enforced. A shift with sft_ce_n=1 still toggles CP and samples Q7.
- vld while busy=1 is ignored silently, with no done and no state change.
- dout holds its value until the next completed shift. Cmd 00 and cmd 10 do not change dout.

## Timing
- Acceptance edge = A; cycle A+k is the k-th cycle after it.
- busy=1 from A+1 until the FIN cycle, inclusive.
- Cmd 00: sft_pl_n low on A+1..A+PL_W; done at A+PL_W+PL_REC+1 (A+7 at defaults).
- Cmd 01: sft_cp high on cycles A+5..A+8, A+13..A+16, and so on. Done and the new dout appear at A+65.
- Cmd 11: done at A+PL_W+PL_REC+65 (A+71 at defaults).
- Cmd 10: sft_ce_n changes at A+1; done at A+1.
- busy=0 in the cycle after FIN. A vld in the FIN cycle is ignored. A vld in the cycle after FIN is accepted.
- rst_n low mid-command: every output returns to its reset value immediately. No done is issued and the partial byte is discarded.
- All outputs are registered, with no combinational path from vld/cmd to the pins.

## Structure
- Package shift_in_pkg: command encodings (CMD_LOAD, CMD_SHIFT, CMD_CE, CMD_LDSH), state enum, PHASES=8, BITS=8.
- Sub-module sync2: 2-flop synchronizer with asynchronous active-low reset, resetting to 0. Reusable by other TWI blocks.
- Everything else stays in one FSM module.

## Test plan
- Reset: hold rst_n=0 -> pl_n=1, cp=0, ce_n=1, dout=00, busy=0, done=0. Release -> outputs unchanged.
- Cmd 10, arg=0 -> sft_ce_n=0 at A+1 with done at A+1. Cmd 10, arg=1 -> ce_n=1.
- Chip model holds 8'hA5. Cmd 00, then cmd 01 -> pl_n low exactly 4 cycles, 8 CP pulses of 4 high/4 low, dout=A5 at A+65, done one cycle.
- Two-chip model with 8'h3C, 8'hC3 -> cmd 11 gives dout=3C at A+71; a following cmd 01 gives dout=C3.
- vld asserted every cycle during cmd 01 -> exactly one done and no extra PL/CP activity. The new command is accepted at FIN+1.
- rst_n pulsed low at bit 4 of a shift -> pins reset at once, dout keeps its reset value 00, no done. The next cmd 11 completes normally.
